seg7_scroll_driver: RTL and testbench



---
 rtl/seg7_scroll_driver_pkg.sv | 27 ++
 rtl/seg7_scroll_driver_tick_gen.sv | 49 ++++
 rtl/seg7_scroll_driver.sv | 110 +++++++++++
 tb/tb_seg7_scroll_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scroll_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scroll_driver_pkg
// Shared constants and helpers for the 7-segment display codebase.
//   SEG_BLANK       : active-low pattern with every segment off
//   SLOT_BLANK_BIT  : slot bit that forces a display blank
//   SLOT_PAT_MSB    : top bit of the active-high segment pattern (g)
//   NUM_SLOTS       : number of processor-written slots / displays
// ---------------------------------------------------------------------------
package seg7_scroll_driver_pkg;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam int         SLOT_BLANK_BIT = 7;
    localparam int         SLOT_PAT_MSB   = 6;
    localparam int         NUM_SLOTS      = 4;

    typedef logic [8:0] slot_t;

    // Convert one slot register into active-low display drive.
    // Bit 8 of the slot is reserved and plays no part in the pattern.
    function automatic logic [6:0] slot_to_hex(input slot_t slot);
        if (slot[SLOT_BLANK_BIT]) begin
            return SEG_BLANK;
        end
        return ~slot[SLOT_PAT_MSB:0];
    endfunction

endpackage

// File: rtl/seg7_scroll_driver_tick_gen.sv
// ---------------------------------------------------------------------------
// seg7_scroll_driver_tick_gen
// Programmable prescaler producing a one-cycle step pulse every TICK_DIV
// enabled cycles.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   en_i     : count enable; when low the count holds
//   clear_i  : synchronous restart to zero; overrides en_i and the step
//   step_o   : high on the enabled cycle where the count is at its terminal
//              value, so the consumer updates on the same edge as the wrap
// ---------------------------------------------------------------------------
module seg7_scroll_driver_tick_gen #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clear_i,
    output logic step_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign step_o  = en_i && !clear_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scroll_driver.sv
// ---------------------------------------------------------------------------
// seg7_scroll_driver
// Drives four active-low 7-segment displays from four 9-bit slot registers,
// optionally rotating the 4-character window at a programmable rate. Any
// write to a slot (any bit changes, including reserved bit 8) restarts the
// rotation at offset 0.
//   clock            : system clock, rising edge
//   Resetn           : asynchronous active-low reset
//   seg_0_in..3_in   : slot contents {reserved, blank, g..a active-high}
//   scroll_en        : 1 = rotate, 0 = freeze offset and prescaler
//   dir              : 0 = offset increments per step, 1 = decrements
//   HEX0..HEX3       : registered display drive, g..a, active-low
//   offset           : current rotation offset
// ---------------------------------------------------------------------------
module seg7_scroll_driver
    import seg7_scroll_driver_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       clock,
    input  logic       Resetn,
    input  logic [8:0] seg_0_in,
    input  logic [8:0] seg_1_in,
    input  logic [8:0] seg_2_in,
    input  logic [8:0] seg_3_in,
    input  logic       scroll_en,
    input  logic       dir,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [1:0] offset
);

    logic [35:0] in_vec;
    logic [35:0] snap_q;
    logic        change;
    logic        step;
    logic [1:0]  off_q;
    logic [1:0]  off_d;
    slot_t       slot   [NUM_SLOTS];
    logic [6:0]  hex_q  [NUM_SLOTS];
    logic [6:0]  hex_d  [NUM_SLOTS];

    assign in_vec  = {seg_3_in, seg_2_in, seg_1_in, seg_0_in};
    assign slot[0] = seg_0_in;
    assign slot[1] = seg_1_in;
    assign slot[2] = seg_2_in;
    assign slot[3] = seg_3_in;

    assign change = (in_vec != snap_q);

    seg7_scroll_driver_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk_i   (clock),
        .rst_ni  (Resetn),
        .en_i    (scroll_en),
        .clear_i (change),
        .step_o  (step)
    );

    // A write wins over a coincident step; 2-bit arithmetic gives the
    // modulo-4 wrap in both directions.
    always_comb begin
        off_d = off_q;
        if (change) begin
            off_d = 2'd0;
        end else if (step) begin
            off_d = dir ? off_q - 2'd1 : off_q + 2'd1;
        end
    end

    // The mux uses the live inputs and next-state offset so a write shows up
    // one edge later already at home position, and a step lands on the same
    // edge as the offset change. Without a change the live inputs equal the
    // snapshot, so this is the same as reading the snapshot.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            hex_d[k] = slot_to_hex(slot[2'(k) + off_d]);
        end
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            snap_q <= '0;
            off_q  <= 2'd0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                hex_q[k] <= SEG_BLANK;
            end
        end else begin
            if (change) begin
                snap_q <= in_vec;
            end
            off_q <= off_d;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign HEX0   = hex_q[0];
    assign HEX1   = hex_q[1];
    assign HEX2   = hex_q[2];
    assign HEX3   = hex_q[3];
    assign offset = off_q;

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scroll_driver
// Self-checking bench: a driver applies inputs on the falling edge and pushes
// the model's prediction for the next rising edge into exp_q; a monitor pops
// one entry per rising edge and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_seg7_scroll_driver;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic [8:0] slot_in [4];
  logic       scroll_en;
  logic       dir;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [1:0] offset;

  seg7_scroll_driver #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clock     (clock),
    .Resetn    (resetn),
    .seg_0_in  (slot_in[0]),
    .seg_1_in  (slot_in[1]),
    .seg_2_in  (slot_in[2]),
    .seg_3_in  (slot_in[3]),
    .scroll_en (scroll_en),
    .dir       (dir),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .offset    (offset)
  );

  // ---------------- scoreboard ----------------
  // Packed prediction: {offset, HEX3, HEX2, HEX1, HEX0}
  logic [29:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a remembered copy of the four slots, a rotation position
  // 0..3 and a count of enabled cycles since the last step.
  logic [8:0] m_snap [4];
  int         m_off;
  int         m_pre;

  function automatic logic [6:0] ref_hex(input logic [8:0] s);
    logic [6:0] pat;
    pat = s[6:0];
    if (s[7]) return 7'h7F;
    return 7'h7F ^ pat;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_snap[i] = 9'h000;
    m_off = 0;
    m_pre = 0;
  endtask

  function automatic logic [29:0] model_outputs();
    logic [29:0] r;
    r = '0;
    r[29:28] = 2'(m_off);
    for (int k = 0; k < 4; k++) r[k*7 +: 7] = ref_hex(slot_in[(k + m_off) % 4]);
    return r;
  endfunction

  task automatic model_edge();
    bit written;
    written = 0;
    for (int i = 0; i < 4; i++) if (slot_in[i] !== m_snap[i]) written = 1;
    if (written) begin
      for (int i = 0; i < 4; i++) m_snap[i] = slot_in[i];
      m_off = 0;
      m_pre = 0;
    end else if (scroll_en) begin
      m_pre = m_pre + 1;
      if (m_pre == TICK_DIV) begin
        m_pre = 0;
        m_off = dir ? (m_off + 3) % 4 : (m_off + 1) % 4;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set; predicts the coming
  // rising edge, then waits for the next falling edge.
  task automatic tick();
    model_edge();
    exp_q.push_back(model_outputs());
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_slots(input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] c, input logic [8:0] d);
    slot_in[0] = a; slot_in[1] = b; slot_in[2] = c; slot_in[3] = d;
  endtask

  function automatic logic [29:0] dut_outputs();
    return {offset, hex3, hex2, hex1, hex0};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) check("cycle_out", dut_outputs(), exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    set_slots(9'h000, 9'h000, 9'h000, 9'h000);
    scroll_en = 1'b0;
    dir       = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check("reset_hold", dut_outputs(), {2'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    @(negedge clock);
    resetn = 1'b1;

    // Static display
    set_slots(9'h006, 9'h05B, 9'h04F, 9'h066);
    tick();
    check("static_load", dut_outputs(), {2'd0, 7'h19, 7'h30, 7'h24, 7'h79});
    ticks(20);
    check("static_hold", dut_outputs(), {2'd0, 7'h19, 7'h30, 7'h24, 7'h79});

    // Scroll forward, then backward
    scroll_en = 1'b1;
    ticks(4);
    check("scroll_off1", dut_outputs(), {2'd1, 7'h79, 7'h19, 7'h30, 7'h24});
    ticks(12);
    check("scroll_wrap0", {28'd0, offset}, 30'd0);
    dir = 1'b1;
    ticks(4);
    check("scroll_dn3", {28'd0, offset}, 30'd3);
    ticks(12);

    // Blank flag on slot 2 follows the slot while rotating
    dir = 1'b0;
    slot_in[2] = 9'h0FF;
    tick();
    check("blank_slot2", {23'd0, hex2}, {23'd0, 7'h7F});
    ticks(8);
    check("blank_rot2", {23'd0, hex0}, {23'd0, 7'h7F});

    // Write restart on the terminal prescaler cycle: offset 2, count 3
    slot_in[2] = 9'h04F;
    tick();
    ticks(11);
    check("pre_restart_off", {28'd0, offset}, 30'd2);
    slot_in[1] = slot_in[1] ^ 9'h100;
    tick();
    check("restart_off0", {28'd0, offset}, 30'd0);
    ticks(3);
    check("restart_no_early", {28'd0, offset}, 30'd0);
    tick();
    check("restart_step4", {28'd0, offset}, 30'd1);

    // Freeze mid-count
    ticks(2);
    scroll_en = 1'b0;
    ticks(10);
    check("freeze_hold", {28'd0, offset}, 30'd1);
    scroll_en = 1'b1;
    ticks(2);
    check("freeze_resume", {28'd0, offset}, 30'd2);

    // TICK_DIV-independent random phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) slot_in[$urandom_range(0, 3)] = 9'($urandom_range(0, 511));
      scroll_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      tick();
    end

    // Asynchronous reset mid-count at offset 2
    dir = 1'b0;
    scroll_en = 1'b1;
    slot_in[0] = slot_in[0] ^ 9'h001;
    tick();
    ticks(9);
    check("pre_reset_off", {28'd0, offset}, 30'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", dut_outputs(), {2'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    model_reset();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    ticks(10);

    @(negedge clock);
    check("queue_drained", 30'(exp_q.size()), 30'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
